// File: rtl/heap_safe_pkg.sv
// Shared types and default sizing for the heap-safety monitor and its
// downstream range tracker.
//
// Contents:
//   HS_N_ENTRIES - default number of tracked ranges
//   HS_ADDR_W    - default address width
//   range_t      - one tracked range: valid flag plus inclusive bounds
package heap_safe_pkg;

    localparam int HS_N_ENTRIES = 8;
    localparam int HS_ADDR_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic [HS_ADDR_W-1:0] first;
        logic [HS_ADDR_W-1:0] last;
    } range_t;

endpackage

// File: rtl/heap_range_tracker_range_match.sv
// range_match: single-entry combinational comparator.
// Reports whether an address falls inside one inclusive range entry.
//
// Parameters:
//   ADDR_W  - address width
//   entry_t - entry struct type with fields valid, first, last
// Ports:
//   entry_i in  entry_t  range entry under test
//   addr_i  in  ADDR_W   address to test
//   hit_o   out 1        entry valid and first <= addr <= last (unsigned)
module range_match
    import heap_safe_pkg::*;
#(
    parameter int  ADDR_W  = HS_ADDR_W,
    parameter type entry_t = range_t
) (
    input  entry_t            entry_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o
);

    assign hit_o = entry_i.valid
                && (addr_i >= entry_i.first)
                && (addr_i <= entry_i.last);

endmodule

// File: rtl/heap_range_tracker.sv
// heap_range_tracker: circular store of inclusive address ranges reported by
// the heap-safety monitor, with a same-cycle "is this address covered"
// lookup, a debug read port and occupancy / overflow status.
//
// Ports:
//   clk_i          in  1        clock
//   rst_ni         in  1        asynchronous active-low reset
//   clear_i        in  1        synchronous flush of entries and status
//   wr_en_i        in  1        record range {wr_first_i, wr_last_i}
//   wr_first_i     in  ADDR_W   range start, inclusive
//   wr_last_i      in  ADDR_W   range end, inclusive
//   lookup_addr_i  in  ADDR_W   address to test
//   lookup_hit_o   out 1        address inside some valid entry
//   lookup_idx_o   out IDX_W    lowest hitting physical slot (0 on miss)
//   rd_index_i     in  IDX_W    debug read slot select
//   rd_sel_last_i  in  1        0 = read first, 1 = read last
//   rd_data_o      out ADDR_W   selected field, 0 if slot invalid
//   count_o        out IDX_W+1  number of valid entries
//   full_o         out 1        count_o == N_ENTRIES
//   overflow_o     out 1        sticky: an entry was overwritten
//   bad_range_o    out 1        sticky: a first > last write was dropped
module heap_range_tracker
    import heap_safe_pkg::*;
#(
    parameter  int N_ENTRIES = HS_N_ENTRIES,
    parameter  int ADDR_W    = HS_ADDR_W,
    localparam int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_first_i,
    input  logic [ADDR_W-1:0] wr_last_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              lookup_hit_o,
    output logic [IDX_W-1:0]  lookup_idx_o,
    input  logic [IDX_W-1:0]  rd_index_i,
    input  logic              rd_sel_last_i,
    output logic [ADDR_W-1:0] rd_data_o,
    output logic [IDX_W:0]    count_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic              bad_range_o
);

    // Local entry type so the address width follows ADDR_W rather than the
    // package default.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] first;
        logic [ADDR_W-1:0] last;
    } entry_t;

    localparam logic [IDX_W:0]  FULL_COUNT = (IDX_W+1)'(N_ENTRIES);
    localparam logic [IDX_W:0]  CNT_ONE    = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] PTR_ONE   = IDX_W'(1);
    localparam logic [ADDR_W:0] ADDR_X_ONE = (ADDR_W+1)'(1);

    entry_t           entry_reg  [N_ENTRIES];
    entry_t           entry_next [N_ENTRIES];
    logic [IDX_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [IDX_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [IDX_W:0]   count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             bad_range_reg, bad_range_next;

    logic [IDX_W-1:0] newest_idx;
    entry_t           newest;
    logic             merge_ok;

    // Newest entry sits just behind the write pointer.
    assign newest_idx = wr_ptr_reg - PTR_ONE;
    assign newest     = entry_reg[newest_idx];

    // Overlap/adjacency test widened by one bit so last = all-ones cannot
    // wrap to 0 and falsely abut a range starting at 0.
    assign merge_ok = (count_reg != '0)
                   && ({1'b0, wr_first_i} <= ({1'b0, newest.last} + ADDR_X_ONE))
                   && (({1'b0, wr_last_i} + ADDR_X_ONE) >= {1'b0, newest.first});

    always_comb begin
        entry_next     = entry_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        bad_range_next = bad_range_reg;

        if (clear_i) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_next[i] = '0;
            end
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            bad_range_next = 1'b0;
        end else if (wr_en_i) begin
            if (wr_first_i > wr_last_i) begin
                bad_range_next = 1'b1;
            end else if (merge_ok) begin
                if (wr_first_i < newest.first) begin
                    entry_next[newest_idx].first = wr_first_i;
                end
                if (wr_last_i > newest.last) begin
                    entry_next[newest_idx].last = wr_last_i;
                end
            end else begin
                // When full, wr_ptr equals rd_ptr, so this overwrites the oldest.
                entry_next[wr_ptr_reg] = '{valid: 1'b1, first: wr_first_i, last: wr_last_i};
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                if (count_reg == FULL_COUNT) begin
                    rd_ptr_next   = rd_ptr_reg + PTR_ONE;
                    overflow_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_reg[i] <= '0;
            end
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            bad_range_reg <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_reg[i] <= entry_next[i];
            end
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            bad_range_reg <= bad_range_next;
        end
    end

    // Lookup: one comparator per slot, registered state only.
    logic [N_ENTRIES-1:0] hit_vec;

    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_match
        range_match #(
            .ADDR_W  (ADDR_W),
            .entry_t (entry_t)
        ) u_range_match (
            .entry_i (entry_reg[gi]),
            .addr_i  (lookup_addr_i),
            .hit_o   (hit_vec[gi])
        );
    end

    // Lowest physical slot wins; scan downward so the last assignment is it.
    always_comb begin
        lookup_idx_o = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                lookup_idx_o = IDX_W'(i);
            end
        end
    end

    assign lookup_hit_o = |hit_vec;

    entry_t rd_entry;
    assign rd_entry  = entry_reg[rd_index_i];
    assign rd_data_o = !rd_entry.valid ? '0
                     : (rd_sel_last_i ? rd_entry.last : rd_entry.first);

    assign count_o     = count_reg;
    assign full_o      = (count_reg == FULL_COUNT);
    assign overflow_o  = overflow_reg;
    assign bad_range_o = bad_range_reg;

endmodule

// File: tb/tb_heap_range_tracker.sv
// Self-checking bench for heap_range_tracker: directed scenarios with
// literal expectations plus randomized traffic, all checked every cycle
// against an age-ordered queue model of the recorded ranges.
module tb_heap_range_tracker;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [AW-1:0] wr_first_i = '0;
    logic [AW-1:0] wr_last_i = '0;
    logic [AW-1:0] lookup_addr_i = '0;
    logic          lookup_hit_o;
    logic [IW-1:0] lookup_idx_o;
    logic [IW-1:0] rd_index_i = '0;
    logic          rd_sel_last_i = 1'b0;
    logic [AW-1:0] rd_data_o;
    logic [IW:0]   count_o;
    logic          full_o;
    logic          overflow_o;
    logic          bad_range_o;

    heap_range_tracker #(.N_ENTRIES(N), .ADDR_W(AW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .wr_en_i       (wr_en_i),
        .wr_first_i    (wr_first_i),
        .wr_last_i     (wr_last_i),
        .lookup_addr_i (lookup_addr_i),
        .lookup_hit_o  (lookup_hit_o),
        .lookup_idx_o  (lookup_idx_o),
        .rd_index_i    (rd_index_i),
        .rd_sel_last_i (rd_sel_last_i),
        .rd_data_o     (rd_data_o),
        .count_o       (count_o),
        .full_o        (full_o),
        .overflow_o    (overflow_o),
        .bad_range_o   (bad_range_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    // Ranges kept oldest-first; each remembers the physical slot it lives in.
    typedef struct {
        int unsigned     slot;
        longint unsigned first;
        longint unsigned last;
    } rng_t;

    rng_t        q[$];
    int unsigned m_wp;
    bit          m_ovf;
    bit          m_bad;

    function automatic void model_reset();
        q.delete();
        m_wp  = 0;
        m_ovf = 1'b0;
        m_bad = 1'b0;
    endfunction

    function automatic void model_step(bit clr, bit en, longint unsigned f, longint unsigned l);
        rng_t e;
        if (clr) begin
            model_reset();
        end else if (en) begin
            if (f > l) begin
                m_bad = 1'b1;
            end else if (q.size() > 0 && f <= q[q.size()-1].last + 1
                         && l + 1 >= q[q.size()-1].first) begin
                e = q[q.size()-1];
                if (f < e.first) e.first = f;
                if (l > e.last)  e.last  = l;
                q[q.size()-1] = e;
            end else begin
                if (q.size() == N) begin
                    void'(q.pop_front());
                    m_ovf = 1'b1;
                end
                e.slot  = m_wp;
                e.first = f;
                e.last  = l;
                q.push_back(e);
                m_wp = (m_wp + 1) % N;
            end
        end
    endfunction

    function automatic void model_lookup(longint unsigned a, output bit hit, output int unsigned idx);
        hit = 1'b0;
        idx = 0;
        for (int s = 0; s < N; s++) begin
            foreach (q[j]) begin
                if (!hit && q[j].slot == s && q[j].first <= a && a <= q[j].last) begin
                    hit = 1'b1;
                    idx = s;
                end
            end
        end
    endfunction

    function automatic longint unsigned model_rd(int unsigned idx, bit sel_last);
        model_rd = 0;
        foreach (q[j]) begin
            if (q[j].slot == idx) model_rd = sel_last ? q[j].last : q[j].first;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(string name, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        bit          e_hit;
        int unsigned e_idx;
        if (chk_en && rst_ni) begin
            model_lookup(lookup_addr_i, e_hit, e_idx);
            check("cyc_hit",   lookup_hit_o, e_hit);
            check("cyc_idx",   lookup_idx_o, e_idx);
            check("cyc_rd",    rd_data_o, model_rd(rd_index_i, rd_sel_last_i));
            check("cyc_count", count_o, q.size());
            check("cyc_full",  full_o, (q.size() == N) ? 1 : 0);
            check("cyc_ovf",   overflow_o, m_ovf);
            check("cyc_bad",   bad_range_o, m_bad);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one clock; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk_i);
        model_step(clear_i, wr_en_i, wr_first_i, wr_last_i);
        #2;
    endtask

    task automatic wr(logic [AW-1:0] f, logic [AW-1:0] l);
        wr_en_i    = 1'b1;
        wr_first_i = f;
        wr_last_i  = l;
        tick();
        wr_en_i = 1'b0;
        $display("write {0x%08h, 0x%08h} count=%0d", f, l, count_o);
    endtask

    task automatic clr();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Reset state
        lookup_addr_i = 32'h8000_1000;
        #1;
        check("rst_hit",   lookup_hit_o, 0);
        check("rst_count", count_o, 0);
        check("rst_full",  full_o, 0);
        check("rst_rd",    rd_data_o, 0);

        // Basic write and lookup latency
        wr_en_i = 1'b1; wr_first_i = 32'h8000_1000; wr_last_i = 32'h8000_100C;
        lookup_addr_i = 32'h8000_100C;
        #1;
        check("hit_write_cycle", lookup_hit_o, 0);
        tick();
        wr_en_i = 1'b0;
        #1;
        check("hit_after_write", lookup_hit_o, 1);
        check("idx_after_write", lookup_idx_o, 0);
        lookup_addr_i = 32'h8000_1010;
        #1;
        check("miss_past_last", lookup_hit_o, 0);

        // Adjacent merge
        clr();
        wr(32'h100, 32'h10F);
        wr(32'h110, 32'h11F);
        #1;
        check("merge_count", count_o, 1);
        rd_index_i = 0; rd_sel_last_i = 1'b0;
        #1;
        check("merge_first", rd_data_o, 32'h100);
        rd_sel_last_i = 1'b1;
        #1;
        check("merge_last", rd_data_o, 32'h11F);
        wr(32'h200, 32'h20F);
        #1;
        check("disjoint_count", count_o, 2);

        // Overflow
        clr();
        for (int k = 0; k < 9; k++) wr(32'h1000 * k, 32'h1000 * k + 3);
        #1;
        check("ovf_count", count_o, 8);
        check("ovf_full",  full_o, 1);
        check("ovf_flag",  overflow_o, 1);
        lookup_addr_i = 32'h0;
        #1;
        check("ovf_old_miss", lookup_hit_o, 0);
        lookup_addr_i = 32'h8000;
        #1;
        check("ovf_new_hit", lookup_hit_o, 1);
        check("ovf_new_idx", lookup_idx_o, 0);

        // Bad range, then clear with simultaneous write
        wr(32'h50, 32'h40);
        #1;
        check("bad_flag",  bad_range_o, 1);
        check("bad_count", count_o, 8);
        clear_i = 1'b1; wr_en_i = 1'b1; wr_first_i = 32'h10; wr_last_i = 32'h20;
        tick();
        clear_i = 1'b0; wr_en_i = 1'b0;
        rd_index_i = 0; rd_sel_last_i = 1'b0; lookup_addr_i = 32'h10;
        #1;
        check("clr_count", count_o, 0);
        check("clr_ovf",   overflow_o, 0);
        check("clr_bad",   bad_range_o, 0);
        check("clr_rd",    rd_data_o, 0);
        check("clr_hit",   lookup_hit_o, 0);

        // Wrap-around boundary must not merge
        wr(32'hFFFF_FFF0, 32'hFFFF_FFFF);
        wr(32'h0, 32'hF);
        #1;
        check("wrap_count", count_o, 2);
        wr(32'h9, 32'h1);

        // Asynchronous reset mid-burst
        wr_en_i = 1'b1; wr_first_i = 32'h300; wr_last_i = 32'h30F;
        lookup_addr_i = 32'h5; rd_index_i = 0; rd_sel_last_i = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_hit",   lookup_hit_o, 0);
        check("arst_count", count_o, 0);
        check("arst_full",  full_o, 0);
        check("arst_ovf",   overflow_o, 0);
        check("arst_bad",   bad_range_o, 0);
        check("arst_rd",    rd_data_o, 0);
        model_reset();
        @(posedge clk_i);
        #2;
        wr_en_i = 1'b0;
        rst_ni  = 1'b1;
        #1;
        check("arst_release_count", count_o, 0);

        // Randomized traffic over a small address window to force merges
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            clear_i = ($urandom_range(0, 149) == 0);
            wr_en_i = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            if (r < 5) begin
                wr_first_i = 32'hFFFF_FF00 + $urandom_range(0, 255);
                wr_last_i  = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : wr_first_i;
            end else if (r < 10) begin
                wr_first_i = $urandom_range(16, 1023);
                wr_last_i  = wr_first_i - $urandom_range(1, 16);
            end else begin
                wr_first_i = $urandom_range(0, 1023);
                wr_last_i  = wr_first_i + $urandom_range(0, 24);
            end
            lookup_addr_i = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255)
                                                         : $urandom_range(0, 1060);
            rd_index_i    = IW'($urandom_range(0, N - 1));
            rd_sel_last_i = $urandom_range(0, 1);
            tick();
        end
        clear_i = 1'b0;
        wr_en_i = 1'b0;
        @(negedge clk_i);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/heap_range_tracker.md
Name: heap_range_tracker

Overview:
- Range store directly downstream of the branch unit's heap-safety monitor.
- The monitor emits one inclusive address range {first,last} whenever a contiguous store run ends. This block records those ranges in an N-entry circular buffer and answers a same-cycle lookup for the monitor: is the current load/store address inside any recorded range.
- It also exposes a debug read port, occupancy and overflow status to the controller.

Parameters:
- N_ENTRIES, 8, number of range entries; power of two, >= 2.
- ADDR_W, 32, address width.
- IDX_W, $clog2(N_ENTRIES), entry index width; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush of all entries and status.
- wr_en_i  in  1  record range this cycle.
- wr_first_i  in  ADDR_W  range start, inclusive.
- wr_last_i  in  ADDR_W  range end, inclusive.
- lookup_addr_i  in  ADDR_W  address to test.
- lookup_hit_o  out  1  lookup_addr_i inside a valid entry.
- lookup_idx_o  out  IDX_W  lowest-index hitting entry; 0 if no hit.
- rd_index_i  in  IDX_W  debug read entry select.
- rd_sel_last_i  in  1  0 = read first, 1 = read last.
- rd_data_o  out  ADDR_W  selected field; 0 if entry invalid.
- count_o  out  IDX_W+1  number of valid entries.
- full_o  out  1  count_o == N_ENTRIES.
- overflow_o  out  1  sticky: an entry was overwritten.
- bad_range_o  out  1  sticky: a write with first > last was dropped.

Behaviour:
- Reset (rst_ni low, async): all valid bits 0, head/tail pointers 0, count 0, overflow_o 0, bad_range_o 0. Lookup and read outputs are therefore 0.
- State per entry: valid, first, last. Global state: wr_ptr (next slot), rd_ptr (oldest), count.
- Lookup is combinational from registered state, with no bypass of a same-cycle write. A write is visible to lookup the cycle after wr_en_i.
- Hit test is unsigned: first <= addr <= last. Ranges are inclusive; a single-byte range has first == last.
- Write processing, evaluated in this priority order on the clock edge:
  1. clear_i = 1: flush exactly as reset; any simultaneous write is discarded.
  2. wr_en_i with wr_first_i > wr_last_i (unsigned): no state change, bad_range_o set.
  3. Merge: count > 0 and the new range overlaps or is adjacent to the newest entry (entry at wr_ptr-1), i.e. wr_first_i <= newest.last+1 and wr_last_i+1 >= newest.first. Newest entry becomes {min(firsts), max(lasts)}; count unchanged.
  4. Allocate, count < N: write slot wr_ptr, set valid, wr_ptr++, count++.
  5. Allocate, count == N: overwrite oldest slot (wr_ptr == rd_ptr), wr_ptr++, rd_ptr++, count stays N, overflow_o set.
- Adjacency arithmetic is computed in ADDR_W+1 bits so last = all-ones and first = 0 cannot wrap into a false merge.
- Pointers wrap modulo N_ENTRIES.
- lookup_idx_o is the physical slot index, not the age order.
- Sticky flags clear only on clear_i or reset.
- Reset asserted mid-burst drops all entries immediately, with no partial-write state.

Decomposition:
- Shared package (heap_safe_pkg): range_t struct {valid, first[ADDR_W], last[ADDR_W]} and default constants HS_N_ENTRIES = 8 and HS_ADDR_W = 32. These are shared with the branch-unit monitor.
- One natural sub-module, range_match: a single-entry combinational comparator (range_t, addr -> hit), instantiated N_ENTRIES times. Priority encode of the hits stays in the top level.

Test Plan:
- Reset, then lookup 0x8000_1000 -> lookup_hit_o = 0, count_o = 0, full_o = 0, rd_data_o = 0.
- Write {0x8000_1000, 0x8000_100C}; next cycle lookup 0x8000_100C -> hit = 1, idx = 0. Lookup 0x8000_1010 -> hit = 0. Lookup in the write cycle itself -> hit = 0.
- Write {0x100, 0x10F}, then {0x110, 0x11F} -> count_o = 1 and entry 0 reads first 0x100, last 0x11F. Then write {0x200, 0x20F} -> count_o = 2.
- Write 9 disjoint ranges {0x1000*k, 0x1000*k+3}, k = 0..8 -> count_o = 8, full_o = 1, overflow_o = 1. Lookup 0x0 misses; lookup 0x8000 hits at idx 0.
- Write {0x50, 0x40} -> no state change, bad_range_o = 1. Then clear_i together with wr_en_i -> count_o = 0, flags 0, no entry written.
- Write {0xFFFF_FFF0, 0xFFFF_FFFF}, then {0x0, 0xF} -> no merge, count_o = 2. Assert rst_ni low mid-sequence -> all outputs 0 asynchronously.
